traffic_phase_ctrl: RTL

Four-approach traffic phase sequencer that drives the phase timer's 4-bit `state` code and advances on its `expired` pulse. It keeps a saturating vehicle queue count per road and grants green in round-robin order, skipping roads with no demand. It chooses primary or extended green from queue depth and drives the per-road lamp outputs. It sits between the lane sensors and the phase timer in the intersection top level.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/lane_queue_counter.sv | 41 ++++
 rtl/traffic_phase_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and FSM states for the traffic phase sequencer.
// Used by both builds (with and without TRAFFIC_EMERGENCY_EN).
package traffic_pkg;

  localparam int NUM_ROADS = 4;

  localparam logic [3:0] CODE_ALLRED = 4'd0;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_e;

  // Road r owns codes 3r+1 (primary), 3r+2 (extended), 3r+3 (yellow).
  function automatic logic [3:0] code_green(input logic [1:0] road);
    return ({2'b00, road} * 4'd3) + 4'd1;
  endfunction

  function automatic logic [3:0] code_ext(input logic [1:0] road);
    return ({2'b00, road} * 4'd3) + 4'd2;
  endfunction

  function automatic logic [3:0] code_yellow(input logic [1:0] road);
    return ({2'b00, road} * 4'd3) + 4'd3;
  endfunction

  function automatic logic [7:0] lamp_vec(input logic [1:0] road, input logic [1:0] lamp);
    logic [7:0] v;
    v = 8'h00;
    v[2*road +: 2] = lamp;
    return v;
  endfunction

endpackage

// File: rtl/lane_queue_counter.sv
// Per-road saturating vehicle queue counter with a registered nonzero flag.
// Simultaneous arrive and depart cancel out.
module lane_queue_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arrive,
  input  logic         depart,
  output logic [W-1:0] count,
  output logic         nz
);

  logic [W-1:0] count_q, count_d;
  logic         nz_q, nz_d;

  always_comb begin
    count_d = count_q;
    if (arrive && !depart && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else if (depart && !arrive && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
    // flag follows the new count so it never lags the counter
    nz_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      nz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      nz_q    <= nz_d;
    end
  end

  assign count = count_q;
  assign nz    = nz_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-road round-robin phase sequencer: queue tracking, green grant and lamp drive.
// Define TRAFFIC_EMERGENCY_EN to add emergency preemption (emer_req / emer_road ports).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int HEAVY_THRESH = 8,
  parameter int QCNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_arrive,
  input  logic [3:0] car_depart,
  input  logic       expired,
`ifdef TRAFFIC_EMERGENCY_EN
  input  logic       emer_req,
  input  logic [1:0] emer_road,
`endif
  output logic [3:0] state,
  output logic [7:0] light,
  output logic [1:0] cur_road,
  output logic [3:0] queue_nz
);

  logic [QCNT_W-1:0] qcnt [NUM_ROADS];
  logic [3:0]        qnz;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_lane
    lane_queue_counter #(.W(QCNT_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .arrive (car_arrive[r]),
      .depart (car_depart[r]),
      .count  (qcnt[r]),
      .nz     (qnz[r])
    );
  end

  phase_e     phase_q, phase_d;
  logic [3:0] code_q, code_d;
  logic [7:0] light_q, light_d;
  logic [1:0] cur_road_q, cur_road_d;
  logic [1:0] last_road_q, last_road_d;

`ifdef TRAFFIC_EMERGENCY_EN
  logic emer_pend_q, emer_pend_d;
  logic emer_grant_q, emer_grant_d;
`endif

  // Round-robin search starting just after the last served road.
  logic       rr_found;
  logic [1:0] rr_pick;
  logic [1:0] rr_cand;

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_road_q;
    rr_cand  = last_road_q;
    for (int i = 1; i <= NUM_ROADS; i++) begin
      rr_cand = last_road_q + 2'(i);
      if (!rr_found && qnz[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  logic       grant_vld;
  logic [1:0] grant_road;
  logic       grant_ext;

  always_comb begin
    grant_vld  = rr_found;
    grant_road = rr_pick;
    grant_ext  = (int'(qcnt[rr_pick]) >= HEAVY_THRESH);
`ifdef TRAFFIC_EMERGENCY_EN
    if (emer_pend_q) begin
      grant_vld  = 1'b1;
      grant_road = emer_road;
      grant_ext  = 1'b1;
    end
`endif
  end

  always_comb begin
    phase_d     = phase_q;
    code_d      = code_q;
    cur_road_d  = cur_road_q;
    last_road_d = last_road_q;
`ifdef TRAFFIC_EMERGENCY_EN
    emer_pend_d  = emer_pend_q;
    emer_grant_d = emer_grant_q;
`endif

    case (phase_q)
      ST_ALLRED: begin
        if (expired && grant_vld) begin
          phase_d    = ST_GREEN;
          cur_road_d = grant_road;
          code_d     = grant_ext ? code_ext(grant_road) : code_green(grant_road);
`ifdef TRAFFIC_EMERGENCY_EN
          if (emer_pend_q) begin
            emer_pend_d  = 1'b0;
            emer_grant_d = 1'b1;
          end
`endif
        end
      end
      ST_GREEN: begin
`ifdef TRAFFIC_EMERGENCY_EN
        if (emer_req && (emer_road != cur_road_q)) begin
          phase_d     = ST_YELLOW;
          code_d      = code_yellow(cur_road_q);
          emer_pend_d = 1'b1;
        end else if (expired) begin
          phase_d = ST_YELLOW;
          code_d  = code_yellow(cur_road_q);
        end
`else
        if (expired) begin
          phase_d = ST_YELLOW;
          code_d  = code_yellow(cur_road_q);
        end
`endif
      end
      ST_YELLOW: begin
        if (expired) begin
          phase_d = ST_ALLRED;
          code_d  = CODE_ALLRED;
`ifdef TRAFFIC_EMERGENCY_EN
          // an emergency green leaves the round-robin pointer untouched
          if (!emer_grant_q) begin
            last_road_d = cur_road_q;
          end
          emer_grant_d = 1'b0;
`else
          last_road_d = cur_road_q;
`endif
        end
      end
      default: begin
        phase_d = ST_ALLRED;
        code_d  = CODE_ALLRED;
      end
    endcase

    case (phase_d)
      ST_GREEN:  light_d = lamp_vec(cur_road_d, LAMP_GREEN);
      ST_YELLOW: light_d = lamp_vec(cur_road_d, LAMP_YELLOW);
      default:   light_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= ST_ALLRED;
      code_q      <= CODE_ALLRED;
      light_q     <= 8'h00;
      cur_road_q  <= 2'd0;
      last_road_q <= 2'd3;
    end else begin
      phase_q     <= phase_d;
      code_q      <= code_d;
      light_q     <= light_d;
      cur_road_q  <= cur_road_d;
      last_road_q <= last_road_d;
    end
  end

`ifdef TRAFFIC_EMERGENCY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emer_pend_q  <= 1'b0;
      emer_grant_q <= 1'b0;
    end else begin
      emer_pend_q  <= emer_pend_d;
      emer_grant_q <= emer_grant_d;
    end
  end
`endif

  assign state    = code_q;
  assign light    = light_q;
  assign cur_road = cur_road_q;
  assign queue_nz = qnz;

endmodule
